// File: rtl/pkt_bufid_dispatch_pkg.sv
// tsn_bufid_pkg: shared widths and dispatcher FSM state encoding
package tsn_bufid_pkg;
   localparam int BUFID_W    = 9;
   localparam int FIFO_CNT_W = 9;
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LOAD = 2'd2} state_t;
endpackage

// File: rtl/pkt_bufid_dispatch_if.sv
// pkt_bufid_dispatch_if: free-FIFO and per-port bufid handshake bundle; BUFID_RESERVE_EN adds reserve-threshold signals
interface pkt_bufid_dispatch_if;
   import tsn_bufid_pkg::*;
   logic               i_dispatch_en;
   logic               o_free_bufid_rd;
   logic [BUFID_W-1:0] iv_free_bufid;
   logic               i_free_bufid_fifo_empty;
`ifdef BUFID_RESERVE_EN
   logic [FIFO_CNT_W-1:0] iv_free_bufid_fifo_rdusedw;
   logic [FIFO_CNT_W-1:0] iv_reserve_threshold;
`endif
   logic               o_pkt_bufid_wr_p0;
   logic               o_pkt_bufid_wr_p1;
   logic [BUFID_W-1:0] ov_pkt_bufid_p0;
   logic [BUFID_W-1:0] ov_pkt_bufid_p1;
   logic               i_pkt_bufid_ack_p0;
   logic               i_pkt_bufid_ack_p1;
   logic [1:0]         ov_dispatch_state;
   logic               o_spurious_ack_pulse;
   modport master (
      input  i_dispatch_en, iv_free_bufid, i_free_bufid_fifo_empty,
`ifdef BUFID_RESERVE_EN
      input  iv_free_bufid_fifo_rdusedw, iv_reserve_threshold,
`endif
      input  i_pkt_bufid_ack_p0, i_pkt_bufid_ack_p1,
      output o_free_bufid_rd, o_pkt_bufid_wr_p0, o_pkt_bufid_wr_p1,
      output ov_pkt_bufid_p0, ov_pkt_bufid_p1, ov_dispatch_state, o_spurious_ack_pulse
   );
   modport slave (
      output i_dispatch_en, iv_free_bufid, i_free_bufid_fifo_empty,
`ifdef BUFID_RESERVE_EN
      output iv_free_bufid_fifo_rdusedw, iv_reserve_threshold,
`endif
      output i_pkt_bufid_ack_p0, i_pkt_bufid_ack_p1,
      input  o_free_bufid_rd, o_pkt_bufid_wr_p0, o_pkt_bufid_wr_p1,
      input  ov_pkt_bufid_p0, ov_pkt_bufid_p1, ov_dispatch_state, o_spurious_ack_pulse
   );
endinterface

// File: rtl/pkt_bufid_dispatch_arb.sv
// bufid_rr_arb2: two-requester round-robin arbiter; ptr holds the last granted port (reset 1 so p0 wins first)
module bufid_rr_arb2 (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] gnt,
   output logic       ptr
);
   // one-hot grant, alternating away from the last winner on contention
   always_comb gnt = !grant_en ? 2'b00 : (req == 2'b11) ? (ptr ? 2'b01 : 2'b10) : req;
   // remember who won most recently
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) ptr <= 1'b1;
      else if (|gnt) ptr <= gnt[1];
endmodule

// File: rtl/pkt_bufid_dispatch.sv
// pkt_bufid_dispatch: prefetches one free bufid per receive port from a shared FIFO; optional macro BUFID_RESERVE_EN
module pkt_bufid_dispatch
   import tsn_bufid_pkg::*;
(
   input logic clk_sys,
   input logic reset,
   pkt_bufid_dispatch_if.master bus
);
   state_t             state, state_nxt;
   logic [1:0]         valid, need, gnt, ack, load;
   logic [BUFID_W-1:0] bufid [2];
   logic               tgt, spur;
   assign ack = {bus.i_pkt_bufid_ack_p1, bus.i_pkt_bufid_ack_p0};
`ifdef BUFID_RESERVE_EN
   assign need = ~valid & {!(bus.iv_free_bufid_fifo_rdusedw <= bus.iv_reserve_threshold), 1'b1};
`else
   assign need = ~valid;
`endif
   // tgt is the arbiter's last winner; it cannot change again until the FSM returns to IDLE
   bufid_rr_arb2 u_arb (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .req      (need),
      .grant_en (state == IDLE && bus.i_dispatch_en && !bus.i_free_bufid_fifo_empty),
      .gnt      (gnt),
      .ptr      (tgt)
   );
   assign load = (state == LOAD) ? {tgt, !tgt} : 2'b00;
   // state register
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   // IDLE waits for a grant, then one read cycle and one load cycle
   always_comb begin
      state_nxt = IDLE;
      state_nxt = (state == IDLE) ? (|gnt ? FETCH : IDLE) : (state == FETCH) ? LOAD : IDLE;
   end
   // slots: load sets valid, honoured ack clears it; acks to empty slots flag a spurious pulse
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         valid    <= 2'b00;
         bufid[0] <= '0;
         bufid[1] <= '0;
         spur     <= 1'b0;
      end else begin
         valid <= (valid & ~ack) | load;
         spur  <= |(ack & ~valid);
         if (load[0]) bufid[0] <= bus.iv_free_bufid;
         if (load[1]) bufid[1] <= bus.iv_free_bufid;
      end
   assign bus.o_free_bufid_rd      = (state == FETCH);
   assign bus.o_pkt_bufid_wr_p0    = valid[0];
   assign bus.o_pkt_bufid_wr_p1    = valid[1];
   assign bus.ov_pkt_bufid_p0      = bufid[0];
   assign bus.ov_pkt_bufid_p1      = bufid[1];
   assign bus.ov_dispatch_state    = state;
   assign bus.o_spurious_ack_pulse = spur;
endmodule

// File: tb/tb_pkt_bufid_dispatch.sv
// tb_pkt_bufid_dispatch: randomized scoreboard bench with a transaction-level dispatcher model
module tb_pkt_bufid_dispatch;
   import tsn_bufid_pkg::*;
   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;
   pkt_bufid_dispatch_if bus ();
   pkt_bufid_dispatch dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;
   logic [BUFID_W-1:0] fifo_q[$];
   logic [BUFID_W-1:0] exp_q0[$];
   logic [BUFID_W-1:0] exp_q1[$];
   int phase, m_tgt, last, thr;
   bit mv0, mv1, exp_spur;
   bit pw0, pw1;
   int ce0, ce1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // monitor: each new offer pops the bufid the model promised that port, and it must stay put while offered
   initial forever begin
      @(negedge clk_sys);
      if (reset) begin
         pw0 = 0;
         pw1 = 0;
      end else begin
         if (bus.o_pkt_bufid_wr_p0) begin
            if (!pw0) begin
               if (exp_q0.size() == 0) begin check("offer_p0_unexpected", 1, 0); ce0 = -1; end
               else ce0 = int'(exp_q0.pop_front());
            end
            if (ce0 >= 0) check("bufid_p0", int'(bus.ov_pkt_bufid_p0), ce0);
         end
         if (bus.o_pkt_bufid_wr_p1) begin
            if (!pw1) begin
               if (exp_q1.size() == 0) begin check("offer_p1_unexpected", 1, 0); ce1 = -1; end
               else ce1 = int'(exp_q1.pop_front());
            end
            if (ce1 >= 0) check("bufid_p1", int'(bus.ov_pkt_bufid_p1), ce1);
         end
         pw0 = bus.o_pkt_bufid_wr_p0;
         pw1 = bus.o_pkt_bufid_wr_p1;
      end
   end

   task automatic drive_idle();
      bus.i_dispatch_en           = 0;
      bus.iv_free_bufid           = '0;
      bus.i_free_bufid_fifo_empty = 1;
      bus.i_pkt_bufid_ack_p0      = 0;
      bus.i_pkt_bufid_ack_p1      = 0;
`ifdef BUFID_RESERVE_EN
      bus.iv_free_bufid_fifo_rdusedw = '0;
      bus.iv_reserve_threshold       = '0;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      #1 reset = 1;
      fifo_q.delete(); exp_q0.delete(); exp_q1.delete();
      phase = 0; mv0 = 0; mv1 = 0; last = 1; exp_spur = 0; thr = 0;
      drive_idle();
      @(negedge clk_sys);
      check("rst_rd", int'(bus.o_free_bufid_rd), 0);
      check("rst_wr_p0", int'(bus.o_pkt_bufid_wr_p0), 0);
      check("rst_wr_p1", int'(bus.o_pkt_bufid_wr_p1), 0);
      check("rst_bufid_p0", int'(bus.ov_pkt_bufid_p0), 0);
      check("rst_bufid_p1", int'(bus.ov_pkt_bufid_p1), 0);
      check("rst_state", int'(bus.ov_dispatch_state), 0);
      check("rst_spurious", int'(bus.o_spurious_ack_pulse), 0);
      #1 reset = 0;
   endtask

   // one cycle: check outputs against the model, answer the FIFO, drive inputs, advance the model
   task automatic step(input bit a0, input bit a1, input bit en);
      bit need0, need1, nv0, nv1;
      @(negedge clk_sys);
      check("wr_p0", int'(bus.o_pkt_bufid_wr_p0), int'(mv0));
      check("wr_p1", int'(bus.o_pkt_bufid_wr_p1), int'(mv1));
      check("rd", int'(bus.o_free_bufid_rd), int'(phase == 1));
      check("state", int'(bus.ov_dispatch_state), phase);
      check("spurious", int'(bus.o_spurious_ack_pulse), int'(exp_spur));
      if (bus.o_free_bufid_rd && fifo_q.size() > 0) bus.iv_free_bufid = fifo_q.pop_front();
      bus.i_pkt_bufid_ack_p0      = a0;
      bus.i_pkt_bufid_ack_p1      = a1;
      bus.i_dispatch_en           = en;
      bus.i_free_bufid_fifo_empty = (fifo_q.size() == 0);
`ifdef BUFID_RESERVE_EN
      bus.iv_free_bufid_fifo_rdusedw = FIFO_CNT_W'(fifo_q.size());
      bus.iv_reserve_threshold       = FIFO_CNT_W'(thr);
`endif
      exp_spur = (a0 && !mv0) || (a1 && !mv1);
      nv0 = mv0 && !a0;
      nv1 = mv1 && !a1;
      if (phase == 2) begin
         if (m_tgt == 0) nv0 = 1;
         else nv1 = 1;
      end
      if (phase == 0) begin
         need0 = !mv0;
         need1 = !mv1;
`ifdef BUFID_RESERVE_EN
         if (fifo_q.size() <= thr) need1 = 0;
`endif
         if (en && fifo_q.size() > 0 && (need0 || need1)) begin
            m_tgt = (need0 && need1) ? (last == 0 ? 1 : 0) : (need1 ? 1 : 0);
            last  = m_tgt;
            if (m_tgt == 0) exp_q0.push_back(fifo_q[0]);
            else exp_q1.push_back(fifo_q[0]);
            phase = 1;
         end
      end else phase = (phase == 1) ? 2 : 0;
      mv0 = nv0;
      mv1 = nv1;
   endtask

   task automatic run(input int n, input bit a0, input bit a1, input bit en);
      for (int i = 0; i < n; i++) step(a0, a1, en);
   endtask

   initial begin
      drive_idle();
      do_reset();
      fifo_q.push_back(9'h010); fifo_q.push_back(9'h011);
      run(8, 0, 0, 1);
      fifo_q.push_back(9'h020); fifo_q.push_back(9'h021);
      step(1, 1, 1);
      run(10, 0, 0, 1);
      step(1, 0, 1);
      fifo_q.push_back(9'h1FF);
      run(25, 0, 0, 1);
      step(1, 0, 1);
      run(3, 0, 0, 1);
      step(0, 1, 1);
      run(4, 0, 0, 1);
      step(0, 1, 1);
      run(3, 0, 0, 1);
      fifo_q.push_back(9'h0A5); fifo_q.push_back(9'h05A);
      step(1, 0, 1);
      run(2, 0, 0, 1);
      run(8, 0, 0, 0);
      run(8, 0, 0, 1);
      fifo_q.push_back(9'h033); fifo_q.push_back(9'h044);
      step(1, 1, 1);
      run(2, 0, 0, 1);
      do_reset();
      fifo_q.push_back(9'h101); fifo_q.push_back(9'h102);
      run(8, 0, 0, 1);
`ifdef BUFID_RESERVE_EN
      do_reset();
      thr = 4;
      for (int i = 0; i < 3; i++) fifo_q.push_back(9'(9'h040 + i));
      run(10, 0, 0, 1);
      for (int i = 0; i < 3; i++) fifo_q.push_back(9'(9'h050 + i));
      run(10, 0, 0, 1);
`endif
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 7) fifo_q.push_back(9'($urandom_range(0, 511)));
`ifdef BUFID_RESERVE_EN
         if ($urandom_range(0, 49) == 0) thr = int'($urandom_range(0, 4));
`endif
         if (c % 500 == 499) do_reset();
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0);
      end
      run(10, 1, 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
